// File: rtl/decode_instr_queue.sv
// Decoded-instruction queue between decode and the micro stage.
// Each accepted result is stamped with a running EIP and handed on in FIFO order.
module decode_instr_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [31:0]      flush_eip,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [6:0]       dec_cmd,
    input  logic [3:0]       dec_cmdex,
    input  logic             dec_is_8bit,
    input  logic             dec_is_complex,
    input  logic             dec_exception_ud,
    input  logic [3:0]       dec_consumed,
    output logic             micro_valid,
    input  logic             micro_ready,
    output logic [6:0]       micro_cmd,
    output logic [3:0]       micro_cmdex,
    output logic             micro_is_8bit,
    output logic             micro_is_complex,
    output logic             micro_exception_ud,
    output logic [3:0]       micro_consumed,
    output logic [31:0]      micro_eip,
    output logic [CNT_W-1:0] queue_count
);
    localparam int                ENTRY_W      = 50;
    localparam logic [0:0]        ST_ACCEPTING = 1'b0;
    localparam logic [0:0]        ST_BLOCKED   = 1'b1;
    localparam logic [31:0]       RESET_EIP    = 32'h0000FFF0;
    localparam logic [CNT_W-1:0]  FULL_COUNT   = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] entry_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic [0:0]         state_r, state_nxt_s;
    logic [31:0]        eip_run_r, eip_run_nxt_s;
    logic               micro_valid_r, dec_ready_r;
    logic               push_s, pop_s;

    assign push_s = dec_valid && dec_ready_r && !flush;
    assign pop_s  = micro_valid_r && micro_ready && !flush;

    // Next-state for pointers, occupancy, running EIP and the #UD block state.
    always_comb begin
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        count_nxt_s   = count_r;
        eip_run_nxt_s = eip_run_r;
        state_nxt_s   = state_r;
        if (flush) begin
            wr_ptr_nxt_s  = {PTR_W{1'b0}};
            rd_ptr_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s   = {CNT_W{1'b0}};
            eip_run_nxt_s = flush_eip;
            state_nxt_s   = ST_ACCEPTING;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s  = wr_ptr_r + PTR_W'(1);
                eip_run_nxt_s = eip_run_r + {28'h0000000, dec_consumed};
            end else begin
                wr_ptr_nxt_s  = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
            // Only a flush or reset leaves BLOCKED; draining does not.
            case (state_r)
                ST_ACCEPTING: begin
                    if (push_s && dec_exception_ud) begin
                        state_nxt_s = ST_BLOCKED;
                    end else begin
                        state_nxt_s = ST_ACCEPTING;
                    end
                end
                ST_BLOCKED: state_nxt_s = ST_BLOCKED;
                default:    state_nxt_s = ST_BLOCKED;
            endcase
        end
    end

    // Control state plus handshake outputs registered from their next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            eip_run_r     <= RESET_EIP;
            state_r       <= ST_ACCEPTING;
            micro_valid_r <= 1'b0;
            dec_ready_r   <= 1'b1;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            count_r       <= count_nxt_s;
            eip_run_r     <= eip_run_nxt_s;
            state_r       <= state_nxt_s;
            micro_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            dec_ready_r   <= (count_nxt_s < FULL_COUNT) && (state_nxt_s == ST_ACCEPTING);
        end
    end

    // Entry storage; cleared by reset only, a flush leaves stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            entry_r[wr_ptr_r] <= {dec_cmd, dec_cmdex, dec_is_8bit, dec_is_complex,
                                  dec_exception_ud, dec_consumed, eip_run_r};
        end
    end

    assign {micro_cmd, micro_cmdex, micro_is_8bit, micro_is_complex,
            micro_exception_ud, micro_consumed, micro_eip} = entry_r[rd_ptr_r];
    assign micro_valid = micro_valid_r;
    assign dec_ready   = dec_ready_r;
    assign queue_count = count_r;

    decode_instr_queue_chk u_chk (
        .clk              (clk),
        .rst              (rst),
        .push             (push_s),
        .dec_exception_ud (dec_exception_ud),
        .dec_consumed     (dec_consumed)
    );
endmodule

// Property checks for the decode queue: a legal instruction is never zero bytes long.
module decode_instr_queue_chk (
    input logic       clk,
    input logic       rst,
    input logic       push,
    input logic       dec_exception_ud,
    input logic [3:0] dec_consumed
);
    a_nonzero_len: assert property (@(posedge clk) disable iff (rst)
        (push && !dec_exception_ud) |-> (dec_consumed != 4'd0));
endmodule

// File: tb/tb_decode_instr_queue.sv
// Bench for decode_instr_queue: directed steps then random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_decode_instr_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, dec_valid, dec_ready, micro_valid, micro_ready;
    logic [31:0] flush_eip, micro_eip;
    logic [6:0]  dec_cmd, micro_cmd;
    logic [3:0]  dec_cmdex, micro_cmdex, dec_consumed, micro_consumed;
    logic        dec_is_8bit, dec_is_complex, dec_exception_ud;
    logic        micro_is_8bit, micro_is_complex, micro_exception_ud;
    logic [2:0]  queue_count;

    typedef struct {
        logic [6:0]  cmd;
        logic [3:0]  cmdex;
        logic        b8;
        logic        cx;
        logic        ud;
        logic [3:0]  len;
        logic [31:0] eip;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_eip;
    bit          m_blk;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    decode_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_eip(flush_eip),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_cmd(dec_cmd),
        .dec_cmdex(dec_cmdex), .dec_is_8bit(dec_is_8bit), .dec_is_complex(dec_is_complex),
        .dec_exception_ud(dec_exception_ud), .dec_consumed(dec_consumed),
        .micro_valid(micro_valid), .micro_ready(micro_ready), .micro_cmd(micro_cmd),
        .micro_cmdex(micro_cmdex), .micro_is_8bit(micro_is_8bit),
        .micro_is_complex(micro_is_complex), .micro_exception_ud(micro_exception_ud),
        .micro_consumed(micro_consumed), .micro_eip(micro_eip), .queue_count(queue_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what the queue must do at this edge given the current inputs.
    task automatic model_edge();
        bit   do_pop, do_push;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_eip = 32'h0000FFF0;
            m_blk = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_eip = flush_eip;
            m_blk = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && micro_ready;
            do_push = dec_valid && (mq.size() < DEPTH) && !m_blk;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.cmd = dec_cmd; e.cmdex = dec_cmdex; e.b8 = dec_is_8bit;
                e.cx = dec_is_complex; e.ud = dec_exception_ud; e.len = dec_consumed;
                e.eip = m_eip;
                mq.push_back(e);
                m_eip = m_eip + 32'(dec_consumed);
                if (dec_exception_ud) m_blk = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("micro_valid", 32'(micro_valid), 32'(mq.size() != 0));
        chk("dec_ready", 32'(dec_ready), 32'((mq.size() < DEPTH) && !m_blk));
        chk("queue_count", 32'(queue_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_cmd", 32'(micro_cmd), 32'(mq[0].cmd));
            chk("head_cmdex", 32'(micro_cmdex), 32'(mq[0].cmdex));
            chk("head_8bit", 32'(micro_is_8bit), 32'(mq[0].b8));
            chk("head_complex", 32'(micro_is_complex), 32'(mq[0].cx));
            chk("head_ud", 32'(micro_exception_ud), 32'(mq[0].ud));
            chk("head_len", 32'(micro_consumed), 32'(mq[0].len));
            chk("head_eip", micro_eip, mq[0].eip);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic ud, input logic [3:0] len);
        dec_valid = v; dec_cmd = c; dec_cmdex = c[3:0]; dec_is_8bit = c[0];
        dec_is_complex = c[1]; dec_exception_ud = ud; dec_consumed = len;
    endtask

    task automatic do_flush(input logic [31:0] addr);
        flush = 1'b1; flush_eip = addr; tick(); flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_eip = 32'h0; micro_ready = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 4'd1);
        m_eip = 32'h0; m_blk = 1'b0;
        #1;
        tick();
        rst = 1'b0;
        chk("rst_cmd", 32'(micro_cmd), 32'h0);
        chk("rst_eip", micro_eip, 32'h0);
        chk("rst_ud", 32'(micro_exception_ud), 32'h0);

        // Two pushes, then a pop.
        drive(1'b1, 7'h12, 1'b0, 4'd2); tick();
        chk("t1_first_eip", micro_eip, 32'h0000FFF0);
        drive(1'b1, 7'h34, 1'b0, 4'd3); tick();
        chk("t1_count2", 32'(queue_count), 32'd2);
        drive(1'b0, 7'h00, 1'b0, 4'd1); micro_ready = 1'b1; tick();
        micro_ready = 1'b0;
        chk("t1_pop_cmd", 32'(micro_cmd), 32'h34);
        chk("t1_pop_eip", micro_eip, 32'h0000FFF2);
        do_flush(32'h00000200);

        // Fill, refuse a 5th, then free one slot.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'(8'h40 + i), 1'b0, 4'(i + 1)); tick();
        end
        chk("t2_full_count", 32'(queue_count), 32'd4);
        chk("t2_full_ready", 32'(dec_ready), 32'd0);
        chk("t2_head_cmd", 32'(micro_cmd), 32'h40);
        drive(1'b0, 7'h00, 1'b0, 4'd1); micro_ready = 1'b1; tick();
        micro_ready = 1'b0;
        chk("t2_ready_back", 32'(dec_ready), 32'd1);
        chk("t2_count3", 32'(queue_count), 32'd3);

        // Streaming through the 32-bit EIP wrap.
        do_flush(32'hFFFFFFFE);
        drive(1'b1, 7'h55, 1'b0, 4'd1); micro_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t3_wrap_eip", micro_eip, 32'h00000000);
        chk("t3_steady", 32'(queue_count), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        micro_ready = 1'b0;

        // #UD blocks acceptance until flush.
        do_flush(32'h00000300);
        drive(1'b1, 7'h66, 1'b1, 4'd0); tick();
        chk("t4_blocked", 32'(dec_ready), 32'd0);
        chk("t4_ud_head", 32'(micro_exception_ud), 32'd1);
        drive(1'b1, 7'h67, 1'b0, 4'd2); tick();
        micro_ready = 1'b1; tick(); tick();
        chk("t4_drained", 32'(micro_valid), 32'd0);
        chk("t4_still_blocked", 32'(dec_ready), 32'd0);
        micro_ready = 1'b0;

        // Flush with three queued, discarding the same-cycle push/pop.
        do_flush(32'h00000400);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'(8'h10 + i), 1'b0, 4'd4); tick();
        end
        micro_ready = 1'b1; flush = 1'b1; flush_eip = 32'h00001000; tick();
        flush = 1'b0; micro_ready = 1'b0;
        chk("t5_flush_count", 32'(queue_count), 32'd0);
        chk("t5_flush_valid", 32'(micro_valid), 32'd0);
        drive(1'b1, 7'h21, 1'b0, 4'd5); tick();
        chk("t5_restart_eip", micro_eip, 32'h00001000);

        // Reset while blocked with two entries.
        drive(1'b1, 7'h22, 1'b1, 4'd1); tick();
        drive(1'b0, 7'h00, 1'b0, 4'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_ready", 32'(dec_ready), 32'd1);
        chk("t6_count", 32'(queue_count), 32'd0);
        chk("t6_cmd", 32'(micro_cmd), 32'h0);
        chk("t6_eip", micro_eip, 32'h0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic ud;
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            flush_eip = $urandom();
            ud = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 3) != 0, 7'($urandom()), ud,
                  ud ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15)));
            micro_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
